// File: rtl/pipe_ctrl.sv
// Pipeline sequencer: fetch PC, per-stage stall vector, branch/exception redirect.
// Optional performance counters are compiled in with `define PIPE_CTRL_PERF_EN.
module pipe_ctrl #(
    parameter logic [31:0] RESET_PC = 32'hBFC00000,
    parameter int unsigned PC_STEP  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_req_if,
    input  logic        stall_req_id,
    input  logic        stall_req_ex,
    input  logic        branch_flag,
    input  logic [31:0] branch_addr,
    input  logic        exc_flag,
    input  logic [31:0] exc_addr,
    output logic [31:0] pc,
    output logic [4:0]  stall,
    output logic        flush,
    output logic        delay_slot
`ifdef PIPE_CTRL_PERF_EN
    ,
    output logic [31:0] perf_stall_cycles,
    output logic [31:0] perf_branches
`endif
);

    typedef enum logic {RUN, BR_PEND} state_e;

    state_e      state_q;
    logic [31:0] pc_q;
    logic [31:0] pend_q;
    logic        ds_q;
    logic        br_acc;
    logic [31:0] pc_inc_d;

    always_comb begin
        stall = 5'b00000;
        if (rst)               stall = 5'b00000;
        else if (exc_flag)     stall = 5'b00000;
        else if (stall_req_ex) stall = 5'b00111;
        else if (stall_req_id) stall = 5'b00011;
        else if (stall_req_if) stall = 5'b00001;
    end

    assign flush    = exc_flag & ~rst;
    assign br_acc   = branch_flag & ~exc_flag & ~stall_req_id & ~stall_req_ex & (state_q == RUN);
    assign pc_inc_d = pc_q + PC_STEP;

    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q    <= RESET_PC;
            state_q <= RUN;
            pend_q  <= '0;
            ds_q    <= 1'b0;
        end else begin
            // Delay-slot marker follows the IF/ID register: held while it is frozen.
            ds_q <= stall[1] ? ds_q : 1'b0;
            case (state_q)
                RUN: begin
                    if (exc_flag) begin
                        pc_q <= exc_addr;
                        ds_q <= 1'b0;
                    end else if (br_acc && stall_req_if) begin
                        pend_q  <= branch_addr;
                        state_q <= BR_PEND;
                    end else if (br_acc) begin
                        pc_q <= branch_addr;
                        ds_q <= 1'b1;
                    end else if (!stall[0]) begin
                        pc_q <= pc_inc_d;
                    end
                end
                BR_PEND: begin
                    if (exc_flag) begin
                        pc_q    <= exc_addr;
                        pend_q  <= '0;
                        ds_q    <= 1'b0;
                        state_q <= RUN;
                    end else if (!stall[0]) begin
                        pc_q    <= pend_q;
                        ds_q    <= 1'b1;
                        state_q <= RUN;
                    end
                end
                default: state_q <= RUN;
            endcase
        end
    end

    assign pc         = pc_q;
    assign delay_slot = ds_q;

`ifdef PIPE_CTRL_PERF_EN
    logic [31:0] perf_stall_q;
    logic [31:0] perf_br_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            perf_stall_q <= '0;
            perf_br_q    <= '0;
        end else begin
            if (stall[0]) perf_stall_q <= perf_stall_q + 32'd1;
            if (br_acc)   perf_br_q    <= perf_br_q + 32'd1;
        end
    end

    assign perf_stall_cycles = perf_stall_q;
    assign perf_branches     = perf_br_q;
`else
    // No performance counters in this build.
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed self-checking bench for pipe_ctrl (default build, no perf counters).
module tb_pipe_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        stall_req_if, stall_req_id, stall_req_ex;
    logic        branch_flag, exc_flag;
    logic [31:0] branch_addr, exc_addr;
    logic [31:0] pc;
    logic [4:0]  stall;
    logic        flush, delay_slot;

    int errs   = 0;
    int checks = 0;

    always #5 clk = ~clk;

    pipe_ctrl dut (
        .clk          (clk),
        .rst          (rst),
        .stall_req_if (stall_req_if),
        .stall_req_id (stall_req_id),
        .stall_req_ex (stall_req_ex),
        .branch_flag  (branch_flag),
        .branch_addr  (branch_addr),
        .exc_flag     (exc_flag),
        .exc_addr     (exc_addr),
        .pc           (pc),
        .stall        (stall),
        .flush        (flush),
        .delay_slot   (delay_slot)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errs++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_pc(input string tag, input logic [31:0] exp_pc, input logic exp_ds);
        chk({tag, ".pc"}, pc, exp_pc);
        chk({tag, ".ds"}, {31'd0, delay_slot}, {31'd0, exp_ds});
    endtask

    task automatic chk_st(input string tag, input logic [4:0] exp_st, input logic exp_fl);
        #1;
        chk({tag, ".stall"}, {27'd0, stall}, {27'd0, exp_st});
        chk({tag, ".flush"}, {31'd0, flush}, {31'd0, exp_fl});
    endtask

    initial begin
        rst = 1'b1; stall_req_if = 0; stall_req_id = 0; stall_req_ex = 0;
        branch_flag = 0; exc_flag = 0; branch_addr = '0; exc_addr = '0;
        tick(); tick();
        chk_pc("reset", 32'hBFC00000, 1'b0);
        chk_st("reset", 5'b00000, 1'b0);
        // requests under reset are masked
        exc_flag = 1; stall_req_ex = 1;
        chk_st("rst_mask", 5'b00000, 1'b0);
        exc_flag = 0; stall_req_ex = 0;

        // sequential fetch
        rst = 0;
        chk_pc("seq0", 32'hBFC00000, 1'b0);
        chk_st("seq0", 5'b00000, 1'b0);
        tick(); chk_pc("seq1", 32'hBFC00004, 1'b0);
        tick(); chk_pc("seq2", 32'hBFC00008, 1'b0);
        tick(); chk_pc("seq3", 32'hBFC0000C, 1'b0);
        tick(); chk_pc("seq4", 32'hBFC00010, 1'b0);

        // taken branch, no stall
        branch_flag = 1; branch_addr = 32'hBFC00100;
        tick(); branch_flag = 0;
        chk_pc("br", 32'hBFC00100, 1'b1);
        tick(); chk_pc("br_next", 32'hBFC00104, 1'b0);

        // back to 0x...10, then branch while fetch stalled 3 cycles
        rst = 1; tick(); rst = 0;
        chk_pc("rst2", 32'hBFC00000, 1'b0);
        tick(); tick(); tick(); tick();
        chk_pc("rst2_seq", 32'hBFC00010, 1'b0);
        branch_flag = 1; branch_addr = 32'hBFC00100; stall_req_if = 1;
        chk_st("pend_st", 5'b00001, 1'b0);
        tick(); branch_flag = 0;
        chk_pc("pend1", 32'hBFC00010, 1'b0);
        chk_st("pend1", 5'b00001, 1'b0);
        tick(); chk_pc("pend2", 32'hBFC00010, 1'b0);
        tick(); chk_pc("pend3", 32'hBFC00010, 1'b0);
        stall_req_if = 0;
        tick(); chk_pc("pend_go", 32'hBFC00100, 1'b1);
        tick(); chk_pc("pend_after", 32'hBFC00104, 1'b0);

        // EX busy blocks the branch
        stall_req_ex = 1; branch_flag = 1; branch_addr = 32'hBFC00200;
        chk_st("ex_st", 5'b00111, 1'b0);
        for (int i = 0; i < 5; i++) begin
            tick(); chk_pc("ex_hold", 32'hBFC00104, 1'b0);
        end
        stall_req_ex = 0; branch_flag = 0;
        tick(); chk_pc("ex_rel", 32'hBFC00108, 1'b0);

        // exception while branch pending
        branch_flag = 1; branch_addr = 32'hBFC00300; stall_req_if = 1;
        tick(); branch_flag = 0;
        chk_pc("pend_x", 32'hBFC00108, 1'b0);
        exc_flag = 1; exc_addr = 32'hBFC00380;
        chk_st("exc_st", 5'b00000, 1'b1);
        tick(); exc_flag = 0; stall_req_if = 0;
        chk_pc("exc", 32'hBFC00380, 1'b0);
        chk_st("exc_after", 5'b00000, 1'b0);
        tick(); chk_pc("exc_next", 32'hBFC00384, 1'b0);

        // delay slot held under ID stall; combined id+if stall; reset mid-stall
        branch_flag = 1; branch_addr = 32'hBFC00500;
        tick(); branch_flag = 0;
        chk_pc("br2", 32'hBFC00500, 1'b1);
        stall_req_id = 1; stall_req_if = 1;
        chk_st("idif_st", 5'b00011, 1'b0);
        tick(); chk_pc("ds_hold", 32'hBFC00500, 1'b1);
        rst = 1;
        chk_st("rst_mid", 5'b00000, 1'b0);
        tick(); rst = 0; stall_req_id = 0; stall_req_if = 0;
        chk_pc("rst_mid", 32'hBFC00000, 1'b0);

        // exception in RUN, then PC wrap
        exc_flag = 1; exc_addr = 32'h80000180;
        tick(); exc_flag = 0;
        chk_pc("exc_run", 32'h80000180, 1'b0);
        branch_flag = 1; branch_addr = 32'hFFFFFFFC;
        tick(); branch_flag = 0;
        chk_pc("wrap0", 32'hFFFFFFFC, 1'b1);
        tick(); chk_pc("wrap1", 32'h00000000, 1'b0);

        // ID hazard blocks the branch
        stall_req_id = 1; branch_flag = 1; branch_addr = 32'h00000700;
        tick(); chk_pc("id_blk", 32'h00000000, 1'b0);
        stall_req_id = 0; branch_flag = 0;
        tick(); chk_pc("id_rel", 32'h00000004, 1'b0);

        // reset while branch pending discards target
        branch_flag = 1; branch_addr = 32'h00000900; stall_req_if = 1;
        tick(); branch_flag = 0; stall_req_if = 0;
        chk_pc("pend_r", 32'h00000004, 1'b0);
        rst = 1;
        tick(); rst = 0;
        chk_pc("pend_rst", 32'hBFC00000, 1'b0);
        tick(); chk_pc("pend_rst_n", 32'hBFC00004, 1'b0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
